therm_chain_dec: RTL and testbench

- Receive-side decoder for the 3-bit cascaded-AND thermometer word {g,f,e}, where e = a&b, f = e&c and g = f&d.
- Each accepted word is validated and decoded to a 2-bit level, then passed through a 2-entry output buffer with valid/ready handshakes on both sides.
- Keeps saturating per-level occurrence counters for the lab status display.
- Sits between the AND-chain stage and downstream consumers.

---
 rtl/therm_chain_dec.sv | 180 ++++++++++++++++++
 tb/tb_therm_chain_dec.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/therm_chain_dec.sv
// therm_chain_dec
// Receive-side decoder for the cascaded-AND thermometer word {g,f,e}
// (e = a&b, f = e&c, g = f&d) coming from the AND-chain stage.
// Each accepted word is validated and decoded to a 2-bit level.
// The result is then held in a 2-entry FIFO with valid/ready on both sides.
// Saturating per-level occurrence counters feed the lab status display.
//
// Optional feature macro: THERM_DEC_ERRCNT_EN
//   When defined, this adds the err_cnt port and a saturating counter of
//   accepted illegal words.
//
// Parameters
//   W_CNT      width of each histogram / error counter
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   in_code is valid
//   in_ready   block can accept a word (low only while the buffer is full)
//   in_code    {g,f,e} thermometer word
//   out_valid  out_level/out_err hold the oldest buffered entry
//   out_ready  consumer takes the head entry
//   out_level  decoded level 0..3
//   out_err    the word was not a legal thermometer code
//   hist_sel   selects which level counter appears on hist_cnt
//   hist_cnt   count of legal words of level hist_sel
//   err_cnt    count of illegal words (only with THERM_DEC_ERRCNT_EN)

module therm_chain_dec #(
  parameter int W_CNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_level,
  output logic             out_err,
  input  logic [1:0]       hist_sel,
  output logic [W_CNT-1:0] hist_cnt
`ifdef THERM_DEC_ERRCNT_EN
  ,
  output logic [W_CNT-1:0] err_cnt
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic [W_CNT-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             accept;
  logic             pop;
  logic [1:0]       dec_level;
  logic             dec_err;
  logic [1:0]       head_level;
  logic             head_err;
  logic [1:0]       tail_level;
  logic             tail_err;
  logic [W_CNT-1:0] hist [4];

  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state != EMPTY);

  // The level is the run of 1s counted up from bit 0. This gives the
  // expected level for legal codes and a best-effort level for broken ones.
  // A word is legal only if it equals the thermometer pattern of that level.
  always_comb begin
    dec_level = 2'd0;
    if (in_code[0]) begin
      dec_level = 2'd1;
      if (in_code[1]) begin
        dec_level = 2'd2;
        if (in_code[2]) dec_level = 2'd3;
      end
    end
    dec_err = (in_code != {dec_level == 2'd3, dec_level[1], dec_level != 2'd0});
  end

  // Occupancy FSM. An accept cannot occur in FULL because in_ready is low there.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = ONE;
      ONE: begin
        if (accept && !pop)      state_next = FULL;
        else if (pop && !accept) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // in_ready is registered from the next state. This keeps the upstream
  // handshake free of any combinational path through out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != FULL);
    end
  end

  // Two-slot buffer that shifts toward the head. The head is always the
  // oldest entry. The tail is only occupied in FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_level <= 2'd0;
      head_err   <= 1'b0;
      tail_level <= 2'd0;
      tail_err   <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head_level <= dec_level;
            head_err   <= dec_err;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_level <= dec_level;
            head_err   <= dec_err;
          end else if (accept) begin
            tail_level <= dec_level;
            tail_err   <= dec_err;
          end
        end
        FULL: begin
          if (pop) begin
            head_level <= tail_level;
            head_err   <= tail_err;
          end
        end
        default: begin
          head_level <= 2'd0;
          head_err   <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are masked when the buffer is empty, so a stale head never leaks out.
  assign out_level = out_valid ? head_level : 2'd0;
  assign out_err   = out_valid ? head_err : 1'b0;

  // Histogram counts legal words at accept time. Each counter sticks at its maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
    end else if (accept && !dec_err && hist[dec_level] != CNT_MAX) begin
      hist[dec_level] <= hist[dec_level] + 1'b1;
    end
  end

  assign hist_cnt = hist[hist_sel];

`ifdef THERM_DEC_ERRCNT_EN
  // Counts accepted illegal words. The counter sticks at its maximum.
  logic [W_CNT-1:0] err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (accept && dec_err && err_q != CNT_MAX) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_therm_chain_dec.sv
// tb_therm_chain_dec
// Self-checking bench for therm_chain_dec. It runs directed scenarios
// followed by randomized traffic. Each is compared against a queue-based
// reference model that decodes words from the thermometer rules directly.

module tb_therm_chain_dec;

  localparam int W_CNT = 2;
  localparam int CNT_MAX = (1 << W_CNT) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_code;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_level;
  logic             out_err;
  logic [1:0]       hist_sel;
  logic [W_CNT-1:0] hist_cnt;
`ifdef THERM_DEC_ERRCNT_EN
  logic [W_CNT-1:0] err_cnt;
`endif

  therm_chain_dec #(.W_CNT(W_CNT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_level (out_level),
    .out_err   (out_err),
    .hist_sel  (hist_sel),
    .hist_cnt  (hist_cnt)
`ifdef THERM_DEC_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int lvl;
    bit err;
  } entry_t;

  entry_t q[$];
  int     hist_m[4];
  int     err_m;
  int     n_checks;
  int     n_fail;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference decode: count the 1s from bit 0 upward. The word is legal only
  // if it is one of the four thermometer patterns.
  function automatic entry_t model_decode(input logic [2:0] code);
    entry_t e;
    e.lvl = 0;
    while (e.lvl < 3 && code[e.lvl]) e.lvl++;
    e.err = !(code == 3'b000 || code == 3'b001 || code == 3'b011 || code == 3'b111);
    return e;
  endfunction

  task automatic clear_model();
    q.delete();
    for (int i = 0; i < 4; i++) hist_m[i] = 0;
    err_m = 0;
  endtask

  task automatic check_model();
    checkOutput("out_valid", {31'd0, out_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
    checkOutput("in_ready", {31'd0, in_ready}, (q.size() < 2) ? 32'd1 : 32'd0);
    if (q.size() != 0) begin
      checkOutput("out_level", {30'd0, out_level}, q[0].lvl);
      checkOutput("out_err", {31'd0, out_err}, {31'd0, q[0].err});
    end
    checkOutput("hist_cnt", {{(32-W_CNT){1'b0}}, hist_cnt}, hist_m[hist_sel]);
`ifdef THERM_DEC_ERRCNT_EN
    checkOutput("err_cnt", {{(32-W_CNT){1'b0}}, err_cnt}, err_m);
`endif
  endtask

  // Called at a negedge. It drives the inputs, checks the current state,
  // clocks one edge, updates the model and returns at the next negedge.
  task automatic applyStimulus(input logic v, input logic [2:0] code,
                               input logic ordy, input logic [1:0] sel);
    bit acc;
    bit pop;
    entry_t e;
    in_valid  = v;
    in_code   = code;
    out_ready = ordy;
    hist_sel  = sel;
    #1;
    check_model();
    acc = v && (q.size() < 2);
    pop = ordy && (q.size() != 0);
    e   = model_decode(code);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back(e);
      if (!e.err) begin
        if (hist_m[e.lvl] < CNT_MAX) hist_m[e.lvl]++;
      end else if (err_m < CNT_MAX) begin
        err_m++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    clear_model();
    check_model();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    in_valid  = 1'b0;
    in_code   = 3'b000;
    out_ready = 1'b0;
    hist_sel  = 2'd0;
    clear_model();
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // Basic decode of the legal codes with one-cycle latency.
    applyStimulus(1, 3'b000, 1, 0);
    applyStimulus(1, 3'b001, 1, 0);
    applyStimulus(1, 3'b011, 1, 1);
    applyStimulus(1, 3'b111, 1, 2);
    for (int s = 0; s < 4; s++) applyStimulus(0, 3'b000, 1, s[1:0]);

    // Illegal codes must be flagged and kept out of the histogram.
    applyStimulus(1, 3'b101, 1, 1);
    applyStimulus(1, 3'b110, 1, 0);
    applyStimulus(0, 3'b000, 1, 0);
    applyStimulus(0, 3'b000, 1, 1);

    // Backpressure case: fill the buffer, hold it, then drain it.
    do_reset();
    applyStimulus(1, 3'b011, 0, 2);
    applyStimulus(1, 3'b111, 0, 3);
    applyStimulus(1, 3'b001, 0, 1);
    applyStimulus(1, 3'b001, 0, 1);
    applyStimulus(1, 3'b001, 1, 1);
    applyStimulus(0, 3'b000, 1, 3);
    applyStimulus(0, 3'b000, 1, 1);
    applyStimulus(0, 3'b000, 1, 1);

    // Accept and pop on the same edge while one entry is held.
    applyStimulus(1, 3'b001, 0, 1);
    applyStimulus(1, 3'b111, 1, 3);
    applyStimulus(1, 3'b000, 1, 0);
    applyStimulus(0, 3'b000, 0, 0);
    applyStimulus(0, 3'b000, 1, 0);

    // Saturation: five level-3 words push the counter to its maximum, where it stays.
    do_reset();
    for (int i = 0; i < 5; i++) applyStimulus(1, 3'b111, 1, 3);
    applyStimulus(0, 3'b000, 1, 3);

    // Asynchronous reset while FULL, checked before any clock edge.
    do_reset();
    applyStimulus(1, 3'b011, 0, 3);
    applyStimulus(1, 3'b111, 0, 3);
    applyStimulus(0, 3'b000, 0, 3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("async_hist_cnt", {{(32-W_CNT){1'b0}}, hist_cnt}, 32'd0);
    checkOutput("async_out_level", {30'd0, out_level}, 32'd0);
    checkOutput("async_out_err", {31'd0, out_err}, 32'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomized traffic, with occasional resets so the counters revisit low values.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      applyStimulus($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
